// File: rtl/read_fmps_test_link_pkg.sv
// Shared types and constants for the FMPS test link receive checker.
package read_fmps_test_link_pkg;

  // Receive framing state: expecting header, expecting payload, or
  // discarding the remainder of a rejected packet.
  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_DATA   = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  typedef logic [2:0] err_code_t;

  // Rejection reasons, reported on errorCode alongside errorStrobe.
  localparam err_code_t ERR_NONE       = 3'd0;
  localparam err_code_t ERR_MAGIC      = 3'd1;  // bad header magic
  localparam err_code_t ERR_SHORT      = 3'd2;  // header carried tlast
  localparam err_code_t ERR_LONG       = 3'd3;  // payload missing tlast
  localparam err_code_t ERR_FLAGS      = 3'd4;  // invalid/reserved flags set
  localparam err_code_t ERR_INDEX      = 3'd5;  // payload index != header index
  localparam err_code_t ERR_DATA_MAGIC = 3'd6;  // bad payload magic
  localparam err_code_t ERR_SEQ        = 3'd7;  // index sequence or FA cycle

  // Payload word layout.
  localparam int PAY_FLAGS_LSB = 29;  // [31:29] FMPS2CC, CC2CC, reserved
  localparam int PAY_INDEX_LSB = 24;  // [28:24]
  localparam int PAY_MAGIC_LSB = 8;   // [23:8]
  localparam int PAY_CYCLE_LSB = 0;   // [7:0]

  localparam logic [15:0] DEFAULT_HEADER_MAGIC = 16'hB6CF;
  localparam logic [15:0] DEFAULT_DATA_MAGIC   = 16'hCACA;

endpackage

// File: rtl/fmps_seq_check.sv
// Expected packet-index tracker for the FMPS receive checker. Holds the
// index the next valid packet should carry and compares both the received
// index and the payload cycle byte against their expected values.
module fmps_seq_check #(
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fa_i,         // FA cycle start this cycle
  input  logic                   check_i,      // payload reached sequence stage
  input  logic [INDEX_WIDTH-1:0] index_i,      // received payload index
  input  logic [7:0]             cycle_byte_i, // received payload cycle byte
  input  logic [7:0]             cycle_exp_i,  // cycle counter valid for this beat
  output logic                   seq_err_o
);

  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = 1;

  logic [INDEX_WIDTH-1:0] exp_index_q;
  logic [INDEX_WIDTH-1:0] exp_index_eff;

  // An FA strobe in the same cycle as the payload restarts the sequence first.
  assign exp_index_eff = fa_i ? '0 : exp_index_q;
  assign seq_err_o     = (index_i != exp_index_eff) || (cycle_byte_i != cycle_exp_i);

  // Advance past every checked packet; on a mismatch this resyncs to received+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_index_q <= '0;
    end else if (check_i) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values, independent of always-block evaluation order.
      exp_index_q <= index_i + IDX_ONE;
    end else if (fa_i) begin
      exp_index_q <= '0;
    end
  end

endmodule

// File: rtl/read_fmps_test_link.sv
// Receive-side checker for the FMPS test link. Validates two-beat
// header/payload packets and reports decoded payloads or error codes.
// Optional build macro FMPS_RX_SEQ_CHECK_EN enables index-sequence and
// FA cycle-byte checking (error code 7).
module read_fmps_test_link
  import read_fmps_test_link_pkg::*;
#(
  parameter int          INDEX_WIDTH     = 5,
  parameter logic [15:0] HEADER_MAGIC    = DEFAULT_HEADER_MAGIC,
  parameter int          MAGIC_START_BIT = 16,
  parameter int          INDEX_START_BIT = 10,
  parameter logic [15:0] DATA_MAGIC      = DEFAULT_DATA_MAGIC,
  parameter int          ERR_COUNT_WIDTH = 16
) (
  input  logic                       auroraUserClk,
  input  logic                       auroraUserResetN,
  input  logic                       auroraChannelUp,
  input  logic                       auroraFAstrobe,
  input  logic [31:0]                FMPS_TEST_AXI_STREAM_RX_tdata,
  input  logic                       FMPS_TEST_AXI_STREAM_RX_tvalid,
  input  logic                       FMPS_TEST_AXI_STREAM_RX_tlast,
  output logic                       packetStrobe,
  output logic [INDEX_WIDTH-1:0]     packetIndex,
  output logic [31:0]                packetData,
  output logic                       errorStrobe,
  output logic [2:0]                 errorCode,
  output logic [INDEX_WIDTH:0]       packetCount,
  output logic [ERR_COUNT_WIDTH-1:0] errorCount,
  output logic [7:0]                 cycleCounter
);

  localparam logic [INDEX_WIDTH:0]       CNT_ONE = 1;
  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_ONE = 1;

  logic        clk, rst_n;
  logic [31:0] data;
  logic        beat, last, fa;

  assign clk   = auroraUserClk;
  assign rst_n = auroraUserResetN;
  assign data  = FMPS_TEST_AXI_STREAM_RX_tdata;
  assign last  = FMPS_TEST_AXI_STREAM_RX_tlast;
  // A down channel freezes everything: beats and FA strobes are ignored.
  assign beat  = FMPS_TEST_AXI_STREAM_RX_tvalid & auroraChannelUp;
  assign fa    = auroraFAstrobe & auroraChannelUp;

  state_e                     state_q, state_d;
  logic [INDEX_WIDTH-1:0]     hdr_index_q;
  logic                       pkt_strobe_q, err_strobe_q;
  logic [INDEX_WIDTH-1:0]     pkt_index_q;
  logic [31:0]                pkt_data_q;
  err_code_t                  err_code_q;
  logic [INDEX_WIDTH:0]       cur_count_q, pkt_count_q;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q;
  logic [7:0]                 cycle_q;

  logic      hdr_latch, early_err, seq_stage, seq_err, pkt_ok, err_fire;
  err_code_t early_code, err_code_d;

  // Framing state register; reset drops any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HEADER;
    else        state_q <= state_d;
  end

  // Next-state and per-beat decode up to the sequence stage.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    hdr_latch  = 1'b0;
    early_err  = 1'b0;
    early_code = ERR_NONE;
    seq_stage  = 1'b0;
    if (!auroraChannelUp) begin
      state_d = ST_HEADER;
    end else if (beat) begin
      unique case (state_q)
        ST_HEADER: begin
          if (data[MAGIC_START_BIT +: 16] != HEADER_MAGIC) begin
            early_err  = 1'b1;
            early_code = ERR_MAGIC;
            state_d    = last ? ST_HEADER : ST_DRAIN;
          end else if (last) begin
            early_err  = 1'b1;
            early_code = ERR_SHORT;
          end else begin
            hdr_latch = 1'b1;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          state_d = ST_HEADER;
          if (!last) begin
            early_err  = 1'b1;
            early_code = ERR_LONG;
            state_d    = ST_DRAIN;
          end else if (data[31:PAY_FLAGS_LSB] != 3'b000) begin
            early_err  = 1'b1;
            early_code = ERR_FLAGS;
          end else if (data[PAY_INDEX_LSB +: INDEX_WIDTH] != hdr_index_q) begin
            early_err  = 1'b1;
            early_code = ERR_INDEX;
          end else if (data[PAY_MAGIC_LSB +: 16] != DATA_MAGIC) begin
            early_err  = 1'b1;
            early_code = ERR_DATA_MAGIC;
          end else begin
            seq_stage = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last) state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end
  end

`ifdef FMPS_RX_SEQ_CHECK_EN
  logic [7:0] cycle_exp;
  // An FA strobe coinciding with the payload applies before the check.
  assign cycle_exp = fa ? (cycle_q + 8'd1) : cycle_q;

  fmps_seq_check #(.INDEX_WIDTH(INDEX_WIDTH)) u_seq_check (
    .clk          (clk),
    .rst_n        (rst_n),
    .fa_i         (fa),
    .check_i      (seq_stage),
    .index_i      (data[PAY_INDEX_LSB +: INDEX_WIDTH]),
    .cycle_byte_i (data[PAY_CYCLE_LSB +: 8]),
    .cycle_exp_i  (cycle_exp),
    .seq_err_o    (seq_err)
  );
`else
  assign seq_err = 1'b0;
`endif

  assign pkt_ok     = seq_stage & ~seq_err;
  assign err_fire   = early_err | (seq_stage & seq_err);
  assign err_code_d = early_err ? early_code : ERR_SEQ;

  // Registered strobes, held output fields, and FA-cycle / error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_index_q  <= '0;
      pkt_strobe_q <= 1'b0;
      err_strobe_q <= 1'b0;
      pkt_index_q  <= '0;
      pkt_data_q   <= '0;
      err_code_q   <= ERR_NONE;
      cur_count_q  <= '0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      cycle_q      <= '0;
    end else begin
      pkt_strobe_q <= pkt_ok;
      err_strobe_q <= err_fire;
      if (hdr_latch) hdr_index_q <= data[INDEX_START_BIT +: INDEX_WIDTH];
      if (pkt_ok) begin
        pkt_index_q <= hdr_index_q;
        pkt_data_q  <= data;
      end
      if (err_fire) begin
        err_code_q <= err_code_d;
        if (err_count_q != '1) err_count_q <= err_count_q + ERR_ONE;
      end
      if (fa) begin
        cycle_q     <= cycle_q + 8'd1;
        pkt_count_q <= cur_count_q;
        // A packet accepted on the FA cycle belongs to the new cycle.
        cur_count_q <= pkt_ok ? CNT_ONE : '0;
      end else if (pkt_ok && cur_count_q != '1) begin
        cur_count_q <= cur_count_q + CNT_ONE;
      end
    end
  end

  assign packetStrobe = pkt_strobe_q;
  assign packetIndex  = pkt_index_q;
  assign packetData   = pkt_data_q;
  assign errorStrobe  = err_strobe_q;
  assign errorCode    = err_code_q;
  assign packetCount  = pkt_count_q;
  assign errorCount   = err_count_q;
  assign cycleCounter = cycle_q;

endmodule

// File: tb/tb_read_fmps_test_link.sv
// Directed self-checking bench for read_fmps_test_link. Expectations for
// error code 7 follow whether FMPS_RX_SEQ_CHECK_EN is defined.
module tb_read_fmps_test_link;

`ifdef FMPS_RX_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chan_up, fa;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic        packetStrobe, errorStrobe;
  logic [4:0]  packetIndex;
  logic [31:0] packetData;
  logic [2:0]  errorCode;
  logic [5:0]  packetCount;
  logic [15:0] errorCount;
  logic [7:0]  cycleCounter;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_errs = 0;

  read_fmps_test_link dut (
    .auroraUserClk                  (clk),
    .auroraUserResetN               (rst_n),
    .auroraChannelUp                (chan_up),
    .auroraFAstrobe                 (fa),
    .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
    .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
    .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
    .packetStrobe                   (packetStrobe),
    .packetIndex                    (packetIndex),
    .packetData                     (packetData),
    .errorStrobe                    (errorStrobe),
    .errorCode                      (errorCode),
    .packetCount                    (packetCount),
    .errorCount                     (errorCount),
    .cycleCounter                   (cycleCounter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] hdr(input logic [4:0] idx);
    return {16'hB6CF, 1'b0, idx, 10'd0};
  endfunction

  function automatic logic [31:0] pay(input logic [4:0] idx, input logic [7:0] cyc);
    return {3'b000, idx, 16'hCACA, cyc};
  endfunction

  // Present one beat for one clock; outputs for it are visible on return.
  task automatic send(input logic [31:0] d, input logic l, input logic f);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    fa     = f;
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    fa     = 1'b0;
  endtask

  task automatic fa_pulse();
    fa = 1'b1;
    @(negedge clk);
    fa = 1'b0;
  endtask

  task automatic no_strobes(input string tag);
    check(tag, {30'd0, packetStrobe, errorStrobe}, 32'd0);
  endtask

  task automatic pkt(input string tag, input logic [4:0] idx, input logic [31:0] p,
                     input logic f, input logic exp_ok, input logic [2:0] code);
    send(hdr(idx), 1'b0, 1'b0);
    no_strobes({tag, "/hdr"});
    send(p, 1'b1, f);
    check({tag, "/pstb"}, packetStrobe, exp_ok);
    check({tag, "/estb"}, errorStrobe, !exp_ok);
    if (exp_ok) begin
      check({tag, "/idx"}, packetIndex, idx);
      check({tag, "/data"}, packetData, p);
    end else begin
      check({tag, "/code"}, errorCode, code);
      exp_errs++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    rst_n = 1'b0; chan_up = 1'b1; fa = 1'b0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    check("rst/strobes", {packetStrobe, errorStrobe, errorCode}, 0);
    check("rst/fields", {packetIndex, packetData[26:0]}, 0);
    check("rst/counts", {packetCount, errorCount, cycleCounter}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle 1: eight good back-to-back packets.
    fa_pulse();
    check("fa1/cycle", cycleCounter, 8'd1);
    for (int i = 0; i < 8; i++) pkt($sformatf("good%0d", i), i[4:0], pay(i[4:0], 8'd1), 1'b0, 1'b1, 3'd0);
    check("c1/errcnt", errorCount, 0);
    fa_pulse();
    check("fa2/pktcnt", packetCount, 6'd8);
    check("fa2/cycle", cycleCounter, 8'd2);

    // Bad header magic, then drained payload, then a good packet.
    send({16'hB6CE, 1'b0, 5'd0, 10'd0}, 1'b0, 1'b0);
    exp_errs++;
    check("magic/estb", errorStrobe, 1'b1);
    check("magic/code", errorCode, 3'd1);
    send(pay(0, 8'd2), 1'b1, 1'b0);
    no_strobes("magic/drain");
    pkt("after_magic", 5'd0, pay(0, 8'd2), 1'b0, 1'b1, 3'd0);

    // Short packet: header with tlast.
    send(hdr(1), 1'b1, 1'b0);
    exp_errs++;
    check("short/estb", errorStrobe, 1'b1);
    check("short/code", errorCode, 3'd2);

    // Long packet: payload without tlast plus an extra beat.
    send(hdr(1), 1'b0, 1'b0);
    send(pay(1, 8'd2), 1'b0, 1'b0);
    exp_errs++;
    check("long/estb", errorStrobe, 1'b1);
    check("long/code", errorCode, 3'd3);
    send(32'h0000_1234, 1'b1, 1'b0);
    no_strobes("long/drain");
    check("long/errcnt", errorCount, exp_errs);
    pkt("after_long", 5'd1, pay(1, 8'd2), 1'b0, 1'b1, 3'd0);

    // Payload content errors.
    pkt("flags", 5'd2, pay(2, 8'd2) | 32'h8000_0000, 1'b0, 1'b0, 3'd4);
    pkt("dmagic", 5'd2, {3'b000, 5'd2, 16'hCACB, 8'd2}, 1'b0, 1'b0, 3'd6);
    pkt("idx_mm", 5'd2, pay(3, 8'd2), 1'b0, 1'b0, 3'd5);
    pkt("good2", 5'd2, pay(2, 8'd2), 1'b0, 1'b1, 3'd0);
    fa_pulse();
    check("fa3/pktcnt", packetCount, 6'd3);
    check("fa3/cycle", cycleCounter, 8'd3);

    // Sequence: 0,1,3 then 4; cycle byte mismatch on 5; then 6.
    pkt("seq0", 5'd0, pay(0, 8'd3), 1'b0, 1'b1, 3'd0);
    pkt("seq1", 5'd1, pay(1, 8'd3), 1'b0, 1'b1, 3'd0);
    pkt("seq3", 5'd3, pay(3, 8'd3), 1'b0, !SEQ_ON, 3'd7);
    pkt("seq4", 5'd4, pay(4, 8'd3), 1'b0, 1'b1, 3'd0);
    pkt("seqcyc", 5'd5, pay(5, 8'd9), 1'b0, !SEQ_ON, 3'd7);
    pkt("seq6", 5'd6, pay(6, 8'd3), 1'b0, 1'b1, 3'd0);
    check("seq/errcnt", errorCount, exp_errs);

    // FA strobe coinciding with payload: checked against cycle 4, index 0.
    exp_cnt = SEQ_ON ? 4 : 6;
    pkt("fa_coinc", 5'd0, pay(0, 8'd4), 1'b1, 1'b1, 3'd0);
    check("fa4/cycle", cycleCounter, 8'd4);
    check("fa4/pktcnt", packetCount, exp_cnt);
    fa_pulse();
    check("fa5/pktcnt", packetCount, 6'd1);
    check("fa5/cycle", cycleCounter, 8'd5);

    // Reset after a header beat: partial packet dropped silently.
    send(hdr(1), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst/counts", {packetCount, errorCount, cycleCounter}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_errs = 0;
    pkt("after_rst", 5'd0, pay(0, 8'd0), 1'b0, 1'b1, 3'd0);

    // Channel down: beats ignored, no errors.
    chan_up = 1'b0;
    send(hdr(1), 1'b0, 1'b0);
    no_strobes("chdn/hdr");
    send(32'hDEAD_0000, 1'b0, 1'b0);
    no_strobes("chdn/bad");
    send(pay(1, 8'd0), 1'b1, 1'b0);
    no_strobes("chdn/pay");
    chan_up = 1'b1;
    pkt("chan_up", 5'd1, pay(1, 8'd0), 1'b0, 1'b1, 3'd0);
    check("end/errcnt", errorCount, exp_errs);
    check("end/cycle", cycleCounter, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
